// File: rtl/uart_rx_oversampled_if.sv
// Bus bundle for uart_rx_oversampled: oversample clock, serial line and
// received-word outputs. Optional parity signals exist when
// UART_RX_PARITY_EN is defined.
// The master side is the pad/baud-gen/consumer environment.
// The slave side is the receiver.
`timescale 1ns/1ps

interface uart_rx_oversampled_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  BCLK;
    logic                  rx;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  framing_error;
    logic                  busy;
`ifdef UART_RX_PARITY_EN
    logic                  parity_odd;
    logic                  parity_error;

    modport master (
        output BCLK, rx, parity_odd,
        input  rx_data, rx_valid, framing_error, busy, parity_error
    );
    modport slave (
        input  BCLK, rx, parity_odd,
        output rx_data, rx_valid, framing_error, busy, parity_error
    );
`else
    modport master (
        output BCLK, rx,
        input  rx_data, rx_valid, framing_error, busy
    );
    modport slave (
        input  BCLK, rx,
        output rx_data, rx_valid, framing_error, busy
    );
`endif
endinterface

// File: rtl/uart_rx_oversampled.sv
// UART receiver driven by an oversample tick (rising edge of BCLK).
// The serial line is synchronised, the start bit is validated at mid-bit,
// and each data bit and the stop bit are sampled one bit period apart.
// Define UART_RX_PARITY_EN to add a parity bit between data and stop,
// the parity_odd input and the parity_error pulse.
`timescale 1ns/1ps

module uart_rx_oversampled #(
    parameter int unsigned DATA_WIDTH        = 8,
    parameter int unsigned OVERSAMPLING_RATE = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_rx_oversampled_if.slave  bus
);
    localparam int unsigned TW = $clog2(OVERSAMPLING_RATE);
    localparam int unsigned BW = $clog2(DATA_WIDTH + 1);
    localparam logic [TW-1:0] MID_TICK  = TW'(OVERSAMPLING_RATE / 2 - 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLING_RATE - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t                state;
    logic                  rx_meta;
    logic                  rx_s;
    logic                  bclk_q;
    logic                  tick;
    logic [TW-1:0]         tick_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] rx_data_r;
    logic                  rx_valid_r;
    logic                  framing_error_r;
    logic                  busy_r;
`ifdef UART_RX_PARITY_EN
    logic                  par_mismatch;
    logic                  parity_error_r;
`endif

    assign tick = bus.BCLK & ~bclk_q;

    // Two-flop synchroniser for the line and one-cycle history of BCLK for tick detection
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            bclk_q  <= 1'b0;
        end else begin
            rx_meta <= bus.rx;
            rx_s    <= rx_meta;
            bclk_q  <= bus.BCLK;
        end
    end

    // Frame FSM with registered outputs; all progress happens on tick cycles only
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            tick_cnt        <= '0;
            bit_cnt         <= '0;
            shift_reg       <= '0;
            rx_data_r       <= '0;
            rx_valid_r      <= 1'b0;
            framing_error_r <= 1'b0;
            busy_r          <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_mismatch    <= 1'b0;
            parity_error_r  <= 1'b0;
`endif
        end else begin
            rx_valid_r      <= 1'b0;
            framing_error_r <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_error_r  <= 1'b0;
`endif
            if (tick) begin
                case (state)
                    IDLE: begin
                        if (!rx_s) begin
                            state    <= START;
                            tick_cnt <= '0;
                            busy_r   <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            par_mismatch <= 1'b0;
`endif
                        end
                    end
                    START: begin
                        if (tick_cnt == MID_TICK) begin
                            tick_cnt <= '0;
                            bit_cnt  <= '0;
                            if (!rx_s) begin
                                state <= DATA;
                            end else begin
                                state  <= IDLE;
                                busy_r <= 1'b0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                    DATA: begin
                        if (tick_cnt == LAST_TICK) begin
                            // Shifting in at the MSB leaves the first line bit at [0]
                            // after DATA_WIDTH samples.
                            shift_reg <= {rx_s, shift_reg[DATA_WIDTH-1:1]};
                            tick_cnt  <= '0;
                            bit_cnt   <= bit_cnt + BW'(1);
                            if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    PARITY: begin
                        if (tick_cnt == LAST_TICK) begin
                            par_mismatch <= ((^shift_reg) ^ bus.parity_odd) != rx_s;
                            tick_cnt     <= '0;
                            state        <= STOP;
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
`endif
                    STOP: begin
                        if (tick_cnt == LAST_TICK) begin
                            rx_data_r <= shift_reg;
                            if (!rx_s) begin
                                framing_error_r <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            end else if (par_mismatch) begin
                                parity_error_r <= 1'b1;
`endif
                            end else begin
                                rx_valid_r <= 1'b1;
                            end
                            tick_cnt <= '0;
                            state    <= IDLE;
                            busy_r   <= 1'b0;
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.rx_data       = rx_data_r;
    assign bus.rx_valid      = rx_valid_r;
    assign bus.framing_error = framing_error_r;
    assign bus.busy          = busy_r;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_error  = parity_error_r;
`endif

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled. Frames are described at word level.
// The expected outcome of each frame (good word, framing error or parity
// error) is queued when the frame is sent. A per-cycle compare process
// matches every output pulse against that queue.
// The held rx_data value is checked between pulses.
`timescale 1ns/1ps

module tb_uart_rx_oversampled;
    localparam int unsigned DW  = 8;
    localparam int unsigned OSR = 16;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    typedef enum int {EV_VALID, EV_FERR, EV_PERR} ev_kind_t;
    typedef struct {
        ev_kind_t      kind;
        logic [DW-1:0] data;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic par_odd_v = 1'b0;
    logic perr_sig;

    uart_rx_oversampled_if #(.DATA_WIDTH(DW)) bus ();

    uart_rx_oversampled #(
        .DATA_WIDTH(DW),
        .OVERSAMPLING_RATE(OSR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef UART_RX_PARITY_EN
    assign bus.parity_odd = par_odd_v;
    assign perr_sig       = bus.parity_error;
`else
    assign perr_sig = 1'b0;
`endif

    always #5 clk = ~clk;

    initial begin
        bus.BCLK = 1'b0;
        #2;
        forever #20 bus.BCLK = ~bus.BCLK;
    end

    ev_t           exp_q[$];
    logic [DW-1:0] model_data = '0;
    int            vectors = 0;
    int            miscompares = 0;
    int            n_valid = 0;
    int            n_ferr = 0;
    int            n_perr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the frame-level expectation queue
    always @(negedge clk) begin
        ev_t      e;
        ev_kind_t act_kind;
        if (rst) begin
            check("reset rx_data", bus.rx_data, 0);
            check("reset rx_valid", bus.rx_valid, 0);
            check("reset framing_error", bus.framing_error, 0);
            check("reset busy", bus.busy, 0);
            check("reset parity_error", perr_sig, 0);
        end else begin
            check("pulse exclusivity", 32'(bus.rx_valid) + 32'(bus.framing_error) + 32'(perr_sig) > 1, 0);
            if (bus.rx_valid || bus.framing_error || perr_sig) begin
                n_valid += int'(bus.rx_valid);
                n_ferr  += int'(bus.framing_error);
                n_perr  += int'(perr_sig);
                act_kind = bus.rx_valid ? EV_VALID : (bus.framing_error ? EV_FERR : EV_PERR);
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected pulse: got kind %0d data %0h, expected no pulse (t=%0t)",
                             act_kind, bus.rx_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse kind", act_kind, e.kind);
                    check("pulse rx_data", bus.rx_data, e.data);
                    model_data = e.data;
                end
            end else begin
                check("held rx_data", bus.rx_data, model_data);
            end
        end
    end

    task automatic ticks(input int n);
        repeat (n) @(posedge bus.BCLK);
    endtask

    task automatic send_bit(input logic b);
        bus.rx = b;
        ticks(OSR);
    endtask

    // Send one frame; the expected outcome follows from the frame rules alone
    task automatic send_frame_p(input logic [DW-1:0] d, input logic stop_bit, input logic pbit);
        ev_t  e;
        logic par_ok;
        par_ok = PAR_EN ? (pbit == ((^d) ^ par_odd_v)) : 1'b1;
        e.data = d;
        e.kind = !stop_bit ? EV_FERR : (!par_ok ? EV_PERR : EV_VALID);
        exp_q.push_back(e);
        send_bit(1'b0);
        for (int i = 0; i < int'(DW); i++) begin
            send_bit(d[i]);
            if (i == 1) check("busy mid-frame", bus.busy, 1);
        end
        if (PAR_EN) send_bit(pbit);
        send_bit(stop_bit);
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic stop_bit);
        send_frame_p(d, stop_bit, (^d) ^ par_odd_v);
    endtask

    task automatic wait_drain(input int max_clks);
        for (int i = 0; i < max_clks && exp_q.size() != 0; i++) @(negedge clk);
        check("expected pulses outstanding", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        bus.rx = 1'b0;
        rst    = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        bus.rx = 1'b1;
        rst    = 1'b0;
        ticks(40);
        check("idle after reset busy", bus.busy, 0);
        check("idle after reset rx_data", bus.rx_data, 0);

        // Nominal 0xA5
        send_frame(8'hA5, 1'b1);
        wait_drain(200);
        check("nominal rx_data", bus.rx_data, 8'hA5);
        check("nominal valid count", n_valid, 1);
        check("nominal ferr count", n_ferr, 0);
        check("nominal busy after stop", bus.busy, 0);

        // False start: 4 ticks low, then a good 0x3C
        bus.rx = 1'b0;
        ticks(4);
        bus.rx = 1'b1;
        ticks(40);
        check("false start busy", bus.busy, 0);
        check("false start valid count", n_valid, 1);
        check("false start ferr count", n_ferr, 0);
        send_frame(8'h3C, 1'b1);
        wait_drain(200);
        check("after false start rx_data", bus.rx_data, 8'h3C);
        check("after false start valid count", n_valid, 2);

        // Framing error on 0x5A, then recovery with 0xFF
        send_frame(8'h5A, 1'b0);
        bus.rx = 1'b1;
        ticks(40);
        wait_drain(200);
        check("framing rx_data", bus.rx_data, 8'h5A);
        check("framing ferr count", n_ferr, 1);
        check("framing valid count", n_valid, 2);
        check("framing busy after resync", bus.busy, 0);
        send_frame(8'hFF, 1'b1);
        wait_drain(200);
        check("recovery rx_data", bus.rx_data, 8'hFF);
        check("recovery valid count", n_valid, 3);

        // Back-to-back, single stop bit each
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h81, 1'b1);
        bus.rx = 1'b1;
        wait_drain(200);
        check("b2b valid count", n_valid, 6);
        check("b2b last rx_data", bus.rx_data, 8'h81);

        // Reset in the middle of data bit 3 of 0x55
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(i[0] ? 1'b0 : 1'b1);
        bus.rx = 1'b0;
        ticks(8);
        check("busy before mid-frame reset", bus.busy, 1);
        @(negedge clk);
        #1;
        rst        = 1'b1;
        bus.rx     = 1'b1;
        model_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
        ticks(200);
        check("mid-frame reset rx_data", bus.rx_data, 0);
        check("mid-frame reset busy", bus.busy, 0);
        check("mid-frame reset valid count", n_valid, 6);
        send_frame(8'h42, 1'b1);
        wait_drain(200);
        check("post-reset rx_data", bus.rx_data, 8'h42);
        check("post-reset valid count", n_valid, 7);

        if (PAR_EN) begin
            par_odd_v = 1'b0;
            send_frame_p(8'h07, 1'b1, 1'b1);
            wait_drain(200);
            check("parity good valid count", n_valid, 8);
            check("parity good perr count", n_perr, 0);
            send_frame_p(8'h07, 1'b1, 1'b0);
            wait_drain(200);
            check("parity bad perr count", n_perr, 1);
            check("parity bad valid count", n_valid, 8);
            check("parity bad rx_data", bus.rx_data, 8'h07);
        end else begin
            check("no parity pulses", n_perr, 0);
        end

        ticks(4);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
